run_controller: RTL and testbench

Sequences execution of the SAP-1 core by generating the global clock-enable pulse and the halt line consumed by the instruction step counter and every other clk_en-gated register.
- Supports four operating modes: free-run with a programmable prescaler, single-cycle step, single-instruction step, and latched halt on the HLT microinstruction.
- Sits between the front-panel and debug inputs and the datapath.
- Replaces the hard-wired clk_en/halt tie-offs.

---
 rtl/run_controller_if.sv | 26 ++
 rtl/run_controller.sv | 97 +++++++++
 tb/tb_run_controller.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_controller_if.sv
// Front-panel/debug control and datapath enable signals of the SAP-1 run controller.
interface run_controller_if #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned CYCLE_WIDTH = 32
);
  logic                   i_run_toggle;
  logic                   i_step;
  logic                   i_step_instr;
  logic                   i_halt_req;
  logic                   i_instr_end;
  logic [DIV_WIDTH-1:0]   i_div;
  logic                   o_clk_en;
  logic                   o_halt;
  logic [2:0]             o_state;
  logic [CYCLE_WIDTH-1:0] o_cycles;

  modport master (
    output i_run_toggle, i_step, i_step_instr, i_halt_req, i_instr_end, i_div,
    input  o_clk_en, o_halt, o_state, o_cycles
  );

  modport slave (
    input  i_run_toggle, i_step, i_step_instr, i_halt_req, i_instr_end, i_div,
    output o_clk_en, o_halt, o_state, o_cycles
  );
endinterface

// File: rtl/run_controller.sv
// SAP-1 run controller: generates the global clock-enable pulse and the halt line for
// free-run (prescaled), single-cycle step, single-instruction step and latched HLT.
module run_controller #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned CYCLE_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  run_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    StStopped   = 3'd0,
    StRunning   = 3'd1,
    StStepCycle = 3'd2,
    StStepInstr = 3'd3,
    StHalted    = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
  logic [CYCLE_WIDTH-1:0] cycles_q;
  logic                   tick;
  logic                   emitting;
  logic                   clk_en;

  always_comb begin
    tick      = (div_cnt_q == '0);
    emitting  = (state_q == StRunning) || (state_q == StStepInstr);
    clk_en    = 1'b0;
    state_d   = state_q;
    // Outside emitting states the prescaler is held at the reload value.
    div_cnt_d = bus.i_div;
    if (emitting && !tick) begin
      div_cnt_d = div_cnt_q - DIV_WIDTH'(1);
    end

    case (state_q)
      StStopped: begin
        if (bus.i_run_toggle) begin
          state_d = StRunning;
        end else if (bus.i_step && bus.i_step_instr) begin
          state_d = StStepInstr;
        end else if (bus.i_step) begin
          state_d = StStepCycle;
        end
      end
      StRunning: begin
        clk_en = tick && !bus.i_halt_req;
        if (tick && bus.i_halt_req) begin
          state_d = StHalted;
        end else if (bus.i_run_toggle) begin
          state_d = StStopped;
        end
      end
      StStepCycle: begin
        // HLT is deliberately not checked: a cycle step always advances.
        clk_en  = 1'b1;
        state_d = StStopped;
      end
      StStepInstr: begin
        clk_en = tick && !bus.i_halt_req;
        if (tick && bus.i_halt_req) begin
          state_d = StHalted;
        end else if (tick && bus.i_instr_end) begin
          state_d = StStopped;
        end else if (bus.i_run_toggle) begin
          state_d = StStopped;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StStopped;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StStopped;
      div_cnt_q <= bus.i_div;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      cycles_q  <= cycles_q + CYCLE_WIDTH'(clk_en);
    end
  end

  assign bus.o_clk_en = clk_en;
  assign bus.o_halt   = (state_q == StHalted);
  assign bus.o_state  = state_q;
  assign bus.o_cycles = cycles_q;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: cycle-by-cycle behavioural model plus directed
// literal expectations for each operating mode and the conflict cases.
module tb_run_controller;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  run_controller_if #(.DIV_WIDTH(DW), .CYCLE_WIDTH(CW)) bus ();

  run_controller #(.DIV_WIDTH(DW), .CYCLE_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: mode numbered as o_state; prescaler as "cycles since last reload" vs latched period.
  int          m_mode   = 0;
  int          m_since  = 0;
  int          m_period = 0;
  logic [31:0] m_cycles = '0;

  function automatic bit m_tick();
    return m_since == m_period;
  endfunction

  function automatic bit m_emit();
    return (m_mode == 1) || (m_mode == 3);
  endfunction

  function automatic bit m_en();
    if (m_emit()) return m_tick() && !bus.i_halt_req;
    return m_mode == 2;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode   <= 0;
      m_since  <= 0;
      m_period <= int'(bus.i_div);
      m_cycles <= '0;
    end else begin
      if (m_en()) m_cycles <= m_cycles + 32'd1;
      if (m_emit() && !m_tick()) begin
        m_since <= m_since + 1;
      end else begin
        m_since  <= 0;
        m_period <= int'(bus.i_div);
      end
      case (m_mode)
        0: begin
          if (bus.i_run_toggle) m_mode <= 1;
          else if (bus.i_step) m_mode <= bus.i_step_instr ? 3 : 2;
        end
        1: begin
          if (m_tick() && bus.i_halt_req) m_mode <= 4;
          else if (bus.i_run_toggle) m_mode <= 0;
        end
        2: m_mode <= 0;
        3: begin
          if (m_tick() && bus.i_halt_req) m_mode <= 4;
          else if (m_tick() && bus.i_instr_end) m_mode <= 0;
          else if (bus.i_run_toggle) m_mode <= 0;
        end
        default: m_mode <= m_mode;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n cycles, comparing DUT outputs against the model mid-cycle.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!rst) begin
        check("model clk_en", 64'(bus.o_clk_en), 64'(m_en()));
        check("model halt", 64'(bus.o_halt), 64'(m_mode == 4));
        check("model state", 64'(bus.o_state), 64'(m_mode));
        check("model cycles", 64'(bus.o_cycles), 64'(m_cycles));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic window(input int len, input bit end5, output int n, output int first,
                        output int last);
    n = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < len; i++) begin
      bus.i_instr_end = end5 && (n == 4);
      #1;
      if (bus.o_clk_en) begin
        if (first < 0) first = i;
        last = i;
        n++;
      end
      cyc(1);
    end
    bus.i_instr_end = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  int n, first, last;

  initial begin
    bus.i_run_toggle = 1'b0;
    bus.i_step       = 1'b0;
    bus.i_step_instr = 1'b0;
    bus.i_halt_req   = 1'b0;
    bus.i_instr_end  = 1'b0;
    bus.i_div        = '0;
    cyc(2);
    rst = 1'b0;
    check("reset state", 64'(bus.o_state), 64'd0);
    check("reset cycles", 64'(bus.o_cycles), 64'd0);
    check("reset clk_en", 64'(bus.o_clk_en), 64'd0);
    check("reset halt", 64'(bus.o_halt), 64'd0);

    // Free run, div 0
    bus.i_run_toggle = 1'b1;
    cyc(1);
    bus.i_run_toggle = 1'b0;
    check("run entry state", 64'(bus.o_state), 64'd1);
    check("run entry clk_en", 64'(bus.o_clk_en), 64'd1);
    cyc(10);
    check("free run cycles", 64'(bus.o_cycles), 64'd10);
    bus.i_run_toggle = 1'b1;
    cyc(1);
    bus.i_run_toggle = 1'b0;
    check("stop state", 64'(bus.o_state), 64'd0);
    check("stop cycles", 64'(bus.o_cycles), 64'd11);

    // Prescale div 3, then div 1 mid-run
    bus.i_div = 16'd3;
    bus.i_run_toggle = 1'b1;
    cyc(1);
    bus.i_run_toggle = 1'b0;
    window(16, 1'b0, n, first, last);
    check("div3 count", 64'(n), 64'd4);
    check("div3 first", 64'(first), 64'd3);
    check("div3 last", 64'(last), 64'd15);
    bus.i_div = 16'd1;
    window(9, 1'b0, n, first, last);
    check("div1 count", 64'(n), 64'd3);
    check("div1 first", 64'(first), 64'd3);
    check("div1 last", 64'(last), 64'd7);
    bus.i_run_toggle = 1'b1;
    cyc(1);
    bus.i_run_toggle = 1'b0;
    check("prescale stop", 64'(bus.o_state), 64'd0);

    // Single-cycle steps
    do_reset();
    for (int s = 0; s < 3; s++) begin
      bus.i_step = 1'b1;
      cyc(1);
      bus.i_step = 1'b0;
      check("step cycle state", 64'(bus.o_state), 64'd2);
      check("step cycle clk_en", 64'(bus.o_clk_en), 64'd1);
      cyc(1);
      check("step cycle return", 64'(bus.o_state), 64'd0);
      cyc(3);
    end
    check("step cycle count", 64'(bus.o_cycles), 64'd3);

    // Instruction steps, div 1
    do_reset();
    bus.i_div = 16'd1;
    bus.i_step_instr = 1'b1;
    for (int s = 0; s < 2; s++) begin
      bus.i_step = 1'b1;
      cyc(1);
      bus.i_step = 1'b0;
      window(15, 1'b1, n, first, last);
      check("instr count", 64'(n), 64'd5);
      check("instr first", 64'(first), 64'd1);
      check("instr last", 64'(last), 64'd9);
      check("instr end state", 64'(bus.o_state), 64'd0);
    end
    check("instr cycles", 64'(bus.o_cycles), 64'd10);
    bus.i_step_instr = 1'b0;

    // Halt during free run
    do_reset();
    bus.i_div = 16'd0;
    bus.i_run_toggle = 1'b1;
    cyc(1);
    bus.i_run_toggle = 1'b0;
    cyc(7);
    bus.i_halt_req = 1'b1;
    #1;
    check("halt cycle clk_en", 64'(bus.o_clk_en), 64'd0);
    cyc(1);
    bus.i_halt_req = 1'b0;
    check("halted state", 64'(bus.o_state), 64'd4);
    check("halted halt", 64'(bus.o_halt), 64'd1);
    for (int i = 0; i < 20; i++) begin
      bus.i_run_toggle = (i % 3 == 0);
      bus.i_step       = (i % 3 == 1);
      cyc(1);
    end
    bus.i_run_toggle = 1'b0;
    bus.i_step = 1'b0;
    check("halt sticky state", 64'(bus.o_state), 64'd4);
    check("halt cycles", 64'(bus.o_cycles), 64'd7);
    do_reset();
    check("halt reset state", 64'(bus.o_state), 64'd0);
    check("halt reset cycles", 64'(bus.o_cycles), 64'd0);
    check("halt reset halt", 64'(bus.o_halt), 64'd0);

    // Conflicts
    bus.i_run_toggle = 1'b1;
    bus.i_step = 1'b1;
    cyc(1);
    bus.i_run_toggle = 1'b0;
    bus.i_step = 1'b0;
    check("toggle beats step", 64'(bus.o_state), 64'd1);
    bus.i_run_toggle = 1'b1;
    bus.i_halt_req = 1'b1;
    #1;
    check("halt vs toggle clk_en", 64'(bus.o_clk_en), 64'd0);
    cyc(1);
    bus.i_run_toggle = 1'b0;
    bus.i_halt_req = 1'b0;
    check("halt beats toggle", 64'(bus.o_state), 64'd4);
    do_reset();
    bus.i_div = 16'd2;
    bus.i_step_instr = 1'b1;
    bus.i_step = 1'b1;
    cyc(1);
    bus.i_step = 1'b0;
    check("instr step entry", 64'(bus.o_state), 64'd3);
    cyc(4);
    do_reset();
    check("mid instr reset state", 64'(bus.o_state), 64'd0);
    check("mid instr reset cycles", 64'(bus.o_cycles), 64'd0);
    window(10, 1'b0, n, first, last);
    check("no enables after reset", 64'(n), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
